move_sequencer: RTL and testbench
=================================

# move_sequencer

Parametrised control sequencer for the register-transfer instruction class: mfhi, mflo, in and out. It drives the DataPath control strobes through a full fetch (T0–T2) and a one-step execute (T3). The memory-read wait is configurable, and it supports single-step (start) and free-running (run) modes, a completion handshake, illegal-opcode flagging and a retired-instruction counter. It sits beside DataPath and replaces hand-sequenced bench stimulus for these instructions.

## Interface
- OPCODE_W, 5, width of opcode field from IR
- MEM_WAIT, 1, cycles Read/MDR_enable held in T1 (legal ≥1)
- CNT_W, 16, width of instr_count
- OP_IN, 5'd22, opcode of in
- OP_OUT, 5'd23, opcode of out
- OP_MFHI, 5'd24, opcode of mfhi
- OP_MFLO, 5'd25, opcode of mflo

- Clock  in  1  system clock, rising edge
- clr  in  1  asynchronous active-high reset
- start  in  1  begin one instruction (sampled in IDLE)
- run  in  1  free-run: chain instructions back-to-back
- ir_opcode  in  OPCODE_W  opcode field of IR (valid from T3)
- PC_out, MAR_enable, Read, MDR_enable, MDR_out, IR_enable, PC_enable, IncPC  out  1 each  fetch strobes
- HI_out, LO_out, in_port_out, out_port_enable, Gra, R_in, R_out  out  1 each  execute strobes
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on instruction retire
- illegal  out  1  one-cycle pulse on unrecognised opcode
- instr_count  out  CNT_W  count of retired legal instructions

## Operation
- States: IDLE, T0, T1, T2, T3, DONE. Registered state, Moore outputs decoded from state (and from ir_opcode in T3 only).
- IDLE: all strobes 0. If start or run is high, go to T0.
- T0: PC_out=1, MAR_enable=1. Go to T1, load wait counter with MEM_WAIT-1.
- T1: Read=1, MDR_enable=1. Stay while the wait counter is ≠0, decrementing each cycle. At 0, go to T2.
- T2: MDR_out=1, IR_enable=1, PC_enable=1, IncPC=1. Go to T3.
- T3, decoded from ir_opcode:
  - mfhi: HI_out, Gra, R_in.
  - mflo: LO_out, Gra, R_in.
  - in: in_port_out, Gra, R_in.
  - out: Gra, R_out, out_port_enable.
  - Any other opcode: no strobes, illegal=1, go to IDLE (no done, no count).
  - Legal opcode: go to DONE.
- DONE: done=1. instr_count increments by 1 at the exit edge, modulo 2^CNT_W (wraps to 0). Go to T0 if run or start is high, else IDLE.
- start is ignored while busy. Lowering run mid-instruction completes the current instruction, then returns to IDLE.
- Only one of HI_out/LO_out/in_port_out/MDR_out/PC_out is ever high in a cycle (single bus driver).

## Timing
- clr high: state=IDLE, wait counter=0, instr_count=0, and every output 0 (including busy, done, illegal), immediately and asynchronously. This holds from any state, including mid-T1.
- Reset release: first action on the first rising edge with clr low.
- Latency: start sampled at edge k, T0 occupies cycle k+1, T1 occupies MEM_WAIT cycles, then T2, T3, DONE. done is high in cycle k+4+MEM_WAIT.
- Back-to-back (run=1): one instruction per 4+MEM_WAIT cycles. T0 directly follows DONE with no IDLE cycle.
- ir_opcode must be stable throughout T3. It is loaded by IR_enable at the T2→T3 edge.
- Illegal: illegal is high during the T3 cycle only. IDLE follows; if run is still high, T0 follows IDLE on the next edge.
- instr_count is visible updated in the cycle after DONE.

## Test plan
- MEM_WAIT=1, pulse start with ir_opcode=25 (mflo):
  - PC_out/MAR_enable high in cycle 1, Read in cycle 2, IR_enable in cycle 3.
  - LO_out+Gra+R_in in cycle 4, done in cycle 5.
  - instr_count=1, then IDLE.
- MEM_WAIT=3, opcode 24 (mfhi): Read/MDR_enable high for exactly 3 consecutive cycles, done in cycle 7 after start, HI_out only in T3.
- Opcode 23 (out): T3 asserts Gra+R_out+out_port_enable with R_in=0. Opcode 22 (in) asserts in_port_out+Gra+R_in.
- Opcode 5'd3: illegal pulses for 1 cycle in T3, no done, instr_count unchanged, state returns to IDLE.
- CNT_W=2, run=1 with opcode 25 for 5 instructions: done every 5 cycles (MEM_WAIT=1) with no IDLE gaps, instr_count sequence 1,2,3,0,1.
- Assert clr asynchronously mid-T1 (between edges): all outputs drop to 0 before the next edge, instr_count=0. After release with start=1, fetch restarts at T0.

Source files
------------

// File: rtl/move_sequencer_if.sv
// ---------------------------------------------------------------------------
// move_sequencer_if
// Signal bundle between the register-transfer sequencer and whatever issues
// instructions to it (bench or higher-level controller).
//   master : drives start / run / ir_opcode, observes strobes and status
//   slave  : the sequencer itself
// Signals:
//   start, run, ir_opcode                      - issue controls
//   PC_out .. IncPC                            - fetch strobes to DataPath
//   HI_out, LO_out, in_port_out,
//   out_port_enable, Gra, R_in, R_out          - execute strobes to DataPath
//   busy, done, illegal, instr_count           - status
// ---------------------------------------------------------------------------
interface move_sequencer_if #(
  parameter int OPCODE_W = 5,
  parameter int CNT_W    = 16
) ();
  logic                start;
  logic                run;
  logic [OPCODE_W-1:0] ir_opcode;

  logic PC_out, MAR_enable, Read, MDR_enable, MDR_out, IR_enable, PC_enable, IncPC;
  logic HI_out, LO_out, in_port_out, out_port_enable, Gra, R_in, R_out;

  logic             busy;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, run, ir_opcode,
    input  PC_out, MAR_enable, Read, MDR_enable, MDR_out, IR_enable, PC_enable, IncPC,
    input  HI_out, LO_out, in_port_out, out_port_enable, Gra, R_in, R_out,
    input  busy, done, illegal, instr_count
  );

  modport slave (
    input  start, run, ir_opcode,
    output PC_out, MAR_enable, Read, MDR_enable, MDR_out, IR_enable, PC_enable, IncPC,
    output HI_out, LO_out, in_port_out, out_port_enable, Gra, R_in, R_out,
    output busy, done, illegal, instr_count
  );
endinterface

// File: rtl/move_sequencer.sv
// ---------------------------------------------------------------------------
// move_sequencer
// Control sequencer for mfhi / mflo / in / out. Walks the DataPath through
// fetch (T0 address, T1 memory read held MEM_WAIT cycles, T2 IR load + PC
// increment) and a single execute step T3, then DONE. Single-step via start,
// back-to-back via run. Unknown opcodes pulse illegal in T3 and return to
// IDLE without retiring.
// Ports:
//   Clock - rising-edge clock
//   clr   - asynchronous active-high reset
//   bus   - move_sequencer_if.slave (issue controls, strobes, status)
// ---------------------------------------------------------------------------
module move_sequencer #(
  parameter int                  OPCODE_W = 5,
  parameter int                  MEM_WAIT = 1,
  parameter int                  CNT_W    = 16,
  parameter logic [OPCODE_W-1:0] OP_IN    = 5'd22,
  parameter logic [OPCODE_W-1:0] OP_OUT   = 5'd23,
  parameter logic [OPCODE_W-1:0] OP_MFHI  = 5'd24,
  parameter logic [OPCODE_W-1:0] OP_MFLO  = 5'd25
) (
  input  logic             Clock,
  input  logic             clr,
  move_sequencer_if.slave  bus
);

  localparam int WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, DONE} state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q,  wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               legal;

  assign legal = (bus.ir_opcode == OP_IN)   || (bus.ir_opcode == OP_OUT) ||
                 (bus.ir_opcode == OP_MFHI) || (bus.ir_opcode == OP_MFLO);

  // State register. Outputs are decoded from state_q, so forcing IDLE here
  // drops every strobe immediately when clr rises, even mid-cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge Clock or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: if (bus.start || bus.run) state_d = T0;
      T0: begin
        state_d = T1;
        wait_d  = WAIT_W'(MEM_WAIT - 1);
      end
      T1: begin
        // Read is held for MEM_WAIT cycles: the counter is preloaded with
        // MEM_WAIT-1 and we leave on the cycle it reads zero.
        if (wait_q != '0) wait_d = wait_q - WAIT_W'(1);
        else              state_d = T2;
      end
      T2: state_d = T3;
      T3: state_d = legal ? DONE : IDLE;
      DONE: begin
        count_d = count_q + CNT_W'(1);
        state_d = (bus.run || bus.start) ? T0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode; only T3 also looks at the opcode. Exactly one bus
  // driver (PC_out / MDR_out / HI_out / LO_out / in_port_out) per state.
  always_comb begin
    bus.PC_out          = 1'b0;
    bus.MAR_enable      = 1'b0;
    bus.Read            = 1'b0;
    bus.MDR_enable      = 1'b0;
    bus.MDR_out         = 1'b0;
    bus.IR_enable       = 1'b0;
    bus.PC_enable       = 1'b0;
    bus.IncPC           = 1'b0;
    bus.HI_out          = 1'b0;
    bus.LO_out          = 1'b0;
    bus.in_port_out     = 1'b0;
    bus.out_port_enable = 1'b0;
    bus.Gra             = 1'b0;
    bus.R_in            = 1'b0;
    bus.R_out           = 1'b0;
    bus.done            = 1'b0;
    bus.illegal         = 1'b0;
    bus.busy            = (state_q != IDLE);
    unique case (state_q)
      T0: begin
        bus.PC_out     = 1'b1;
        bus.MAR_enable = 1'b1;
      end
      T1: begin
        bus.Read       = 1'b1;
        bus.MDR_enable = 1'b1;
      end
      T2: begin
        bus.MDR_out   = 1'b1;
        bus.IR_enable = 1'b1;
        bus.PC_enable = 1'b1;
        bus.IncPC     = 1'b1;
      end
      T3: begin
        if (bus.ir_opcode == OP_MFHI) begin
          bus.HI_out = 1'b1;
          bus.Gra    = 1'b1;
          bus.R_in   = 1'b1;
        end else if (bus.ir_opcode == OP_MFLO) begin
          bus.LO_out = 1'b1;
          bus.Gra    = 1'b1;
          bus.R_in   = 1'b1;
        end else if (bus.ir_opcode == OP_IN) begin
          bus.in_port_out = 1'b1;
          bus.Gra         = 1'b1;
          bus.R_in        = 1'b1;
        end else if (bus.ir_opcode == OP_OUT) begin
          bus.Gra             = 1'b1;
          bus.R_out           = 1'b1;
          bus.out_port_enable = 1'b1;
        end else begin
          bus.illegal = 1'b1;
        end
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_move_sequencer
// Two sequencer instances: A (MEM_WAIT=1, CNT_W=2) and B (MEM_WAIT=3,
// CNT_W=16). Issuing an instruction pushes its expected per-cycle strobe
// trace into a queue; a negedge monitor pops and compares each cycle, and
// expects all-quiet IDLE when its queue is empty.
// ---------------------------------------------------------------------------
module tb_move_sequencer;

  typedef struct packed {
    logic pc_out, mar_en, rd, mdr_en, mdr_out, ir_en, pc_en, inc_pc;
    logic hi_out, lo_out, inp_out, outp_en, gra, r_in, r_out;
    logic busy, done, illegal;
  } strb_t;

  typedef struct {
    strb_t s;
    int    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic clr_a, clr_b;
  always #5 clk = ~clk;

  move_sequencer_if #(.OPCODE_W(5), .CNT_W(2))  ifa ();
  move_sequencer_if #(.OPCODE_W(5), .CNT_W(16)) ifb ();

  move_sequencer #(.MEM_WAIT(1), .CNT_W(2))  dut_a (.Clock(clk), .clr(clr_a), .bus(ifa));
  move_sequencer #(.MEM_WAIT(3), .CNT_W(16)) dut_b (.Clock(clk), .clr(clr_b), .bus(ifb));

  strb_t obs_a, obs_b;
  assign obs_a = {ifa.PC_out, ifa.MAR_enable, ifa.Read, ifa.MDR_enable, ifa.MDR_out,
                  ifa.IR_enable, ifa.PC_enable, ifa.IncPC, ifa.HI_out, ifa.LO_out,
                  ifa.in_port_out, ifa.out_port_enable, ifa.Gra, ifa.R_in, ifa.R_out,
                  ifa.busy, ifa.done, ifa.illegal};
  assign obs_b = {ifb.PC_out, ifb.MAR_enable, ifb.Read, ifb.MDR_enable, ifb.MDR_out,
                  ifb.IR_enable, ifb.PC_enable, ifb.IncPC, ifb.HI_out, ifb.LO_out,
                  ifb.in_port_out, ifb.out_port_enable, ifb.Gra, ifb.R_in, ifb.R_out,
                  ifb.busy, ifb.done, ifb.illegal};

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   cnt_a = 0;
  int   cnt_b = 0;
  bit   mon_en_a = 0;
  bit   mon_en_b = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected strobes for phase 0=T0 1=T1 2=T2 3=T3 4=DONE.
  function automatic strb_t exp_strb(input int ph, input logic [4:0] op);
    strb_t s;
    s = '0;
    s.busy = 1'b1;
    case (ph)
      0: begin s.pc_out = 1; s.mar_en = 1; end
      1: begin s.rd = 1; s.mdr_en = 1; end
      2: begin s.mdr_out = 1; s.ir_en = 1; s.pc_en = 1; s.inc_pc = 1; end
      3: case (op)
           5'd24:   begin s.hi_out = 1; s.gra = 1; s.r_in = 1; end
           5'd25:   begin s.lo_out = 1; s.gra = 1; s.r_in = 1; end
           5'd22:   begin s.inp_out = 1; s.gra = 1; s.r_in = 1; end
           5'd23:   begin s.gra = 1; s.r_out = 1; s.outp_en = 1; end
           default: s.illegal = 1;
         endcase
      default: s.done = 1;
    endcase
    return s;
  endfunction

  task automatic push_instr(input bit on_b, input int mw, input logic [4:0] op);
    int   c;
    bit   legal;
    exp_t e;
    c     = on_b ? cnt_b : cnt_a;
    legal = (op == 5'd22) || (op == 5'd23) || (op == 5'd24) || (op == 5'd25);
    for (int ph = 0; ph < 5; ph++) begin
      int reps;
      if (ph == 4 && !legal) break;
      reps = (ph == 1) ? mw : 1;
      for (int r = 0; r < reps; r++) begin
        e.s   = exp_strb(ph, op);
        e.cnt = c;
        if (on_b) q_b.push_back(e);
        else      q_a.push_back(e);
      end
    end
    if (legal) begin
      if (on_b) cnt_b = (cnt_b + 1) % 65536;
      else      cnt_a = (cnt_a + 1) % 4;
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (mon_en_a) begin
      if (q_a.size() != 0) e = q_a.pop_front();
      else begin e.s = '0; e.cnt = cnt_a; end
      check("A_strobes", 32'(obs_a), 32'(e.s));
      check("A_count", 32'(ifa.instr_count), 32'(e.cnt));
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (mon_en_b) begin
      if (q_b.size() != 0) e = q_b.pop_front();
      else begin e.s = '0; e.cnt = cnt_b; end
      check("B_strobes", 32'(obs_b), 32'(e.s));
      check("B_count", 32'(ifb.instr_count), 32'(e.cnt));
    end
  end

  // Wait (bounded) until the chosen scoreboard drains, then one idle cycle.
  task automatic wait_drain(input bit on_b);
    for (int i = 0; i < 200; i++) begin
      if ((on_b ? q_b.size() : q_a.size()) == 0) break;
      @(negedge clk);
    end
    check(on_b ? "B_drain_timeout" : "A_drain_timeout",
          32'(on_b ? q_b.size() : q_a.size()), 32'd0);
    @(negedge clk);
    #1;
  endtask

  // Single-step issue; caller is at negedge+1.
  task automatic issue_a(input logic [4:0] op);
    ifa.ir_opcode = op;
    push_instr(1'b0, 1, op);
    ifa.start = 1'b1;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    wait_drain(1'b0);
  endtask

  task automatic issue_b(input logic [4:0] op);
    ifb.ir_opcode = op;
    push_instr(1'b1, 3, op);
    ifb.start = 1'b1;
    @(posedge clk);
    #1 ifb.start = 1'b0;
    wait_drain(1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_a = 1'b1;
    clr_b = 1'b1;
    ifa.start = 1'b0; ifa.run = 1'b0; ifa.ir_opcode = '0;
    ifb.start = 1'b0; ifb.run = 1'b0; ifb.ir_opcode = '0;

    #3;
    check("A_reset_strobes", 32'(obs_a), 32'd0);
    check("A_reset_count",   32'(ifa.instr_count), 32'd0);
    check("B_reset_strobes", 32'(obs_b), 32'd0);
    check("B_reset_count",   32'(ifb.instr_count), 32'd0);

    @(negedge clk); #1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    mon_en_a = 1;
    mon_en_b = 1;
    @(negedge clk); #1;

    // Instance A: single-step each opcode class, then an illegal one.
    issue_a(5'd25);   // mflo
    issue_a(5'd23);   // out
    issue_a(5'd22);   // in
    issue_a(5'd3);    // illegal: no done, count unchanged

    // Instance B: long memory wait with mfhi.
    issue_b(5'd24);

    // Instance B: clr raised mid-T1, between edges.
    mon_en_b = 0;
    ifb.ir_opcode = 5'd24;
    ifb.start = 1'b1;
    @(posedge clk);              // -> T0
    #1 ifb.start = 1'b0;
    @(posedge clk);              // -> T1 (first of three)
    #3 clr_b = 1'b1;
    #1;
    check("B_clr_strobes", 32'(obs_b), 32'd0);
    check("B_clr_count",   32'(ifb.instr_count), 32'd0);
    @(posedge clk);
    @(negedge clk); #1;
    q_b.delete();
    cnt_b = 0;
    clr_b = 1'b0;
    mon_en_b = 1;
    issue_b(5'd24);              // fetch restarts cleanly at T0

    // Instance A: clear the counter, then free-run five mflo.
    mon_en_a = 0;
    clr_a = 1'b1;
    #2;
    check("A_clr_count", 32'(ifa.instr_count), 32'd0);
    clr_a = 1'b0;
    q_a.delete();
    cnt_a = 0;
    mon_en_a = 1;
    @(negedge clk); #1;
    ifa.ir_opcode = 5'd25;
    for (int n = 0; n < 5; n++) push_instr(1'b0, 1, 5'd25);
    ifa.run = 1'b1;
    @(posedge clk);              // run sampled; first T0 follows
    repeat (22) @(posedge clk);  // inside the fifth instruction
    #1 ifa.run = 1'b0;
    wait_drain(1'b0);

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
